amp_seq_ctrl: RTL and testbench
===============================

Name: amp_seq_ctrl

Overview:
Power-up/configuration/mute sequencer for the external I2S amplifier.
- Owns amp_nenable and amp_nmute.
- Issues a table of amplifier register writes through the shared byte-level I2C master (cmd handshake).
- Gates unmute on receiver lock.
- Sits in toi2s_tt_top between the register bank, the rx lock detector and the amp I2C master.

Parameters:
CNT_W, 20, width of the delay timer.
T_PWRUP, 480000, cycles from enable release to first I2C write.
T_UNMUTE, 48000, cycles of continuous lock before nmute is released.
T_MUTE, 4800, cycles nmute is held low before nenable is raised on shutdown.
NUM_CFG, 4, number of config writes (table depth, 1..16).
MAX_RETRY, 3, NACK retries per write before FAULT.
AMP_ADDR, 7'h2C, 7-bit amplifier I2C address.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ena  in  1  tile enable; low requests shutdown
seq_go  in  1  register-bank start bit (level)
lock_in  in  1  receiver/I2S stream lock (synchronous to clk)
tbl_idx  out  4  config table index
tbl_reg  in  8  register address at tbl_idx (combinational)
tbl_data  in  8  register data at tbl_idx (combinational)
cmd_valid  out  1  I2C write request
cmd_ready  in  1  I2C master accepts request
cmd_addr  out  7  = AMP_ADDR
cmd_reg  out  8  registered copy of tbl_reg
cmd_data  out  8  registered copy of tbl_data
cmd_done  in  1  one-cycle pulse: transfer finished
cmd_nack  in  1  valid with cmd_done; 1 = NACK
amp_nenable  out  1  amplifier enable, active-low
amp_nmute  out  1  amplifier mute, active-low
seq_state  out  3  current state encoding
seq_fault  out  1  sticky fault flag

Behaviour:
Reset values:
- amp_nenable=1, amp_nmute=0, cmd_valid=0, tbl_idx=0.
- cmd_reg=cmd_data=0, seq_fault=0, state OFF.
- All outputs are registered.

States (encoding in seq_state): OFF=0, PWRUP=1, CFG_REQ=2, CFG_WAIT=3, LOCKWAIT=4, RUN=5, MUTEDN=6, FAULT=7.
- OFF: nenable=1, nmute=0. On ena&seq_go: go PWRUP, nenable<=0, timer cleared.
- PWRUP: count T_PWRUP cycles, then CFG_REQ with tbl_idx=0 and retry count=0.
- CFG_REQ: capture tbl_reg/tbl_data into cmd_reg/cmd_data and raise cmd_valid.
  - cmd_valid stays high and cmd_* stay stable until the cycle cmd_ready=1.
  - On that cycle: cmd_valid<=0, go CFG_WAIT.
- CFG_WAIT, on cmd_done:
  - cmd_nack=0: tbl_idx+1. If it was NUM_CFG-1, go LOCKWAIT with tbl_idx<=0; else go CFG_REQ.
  - cmd_nack=1: retry<MAX_RETRY → retry+1, back to CFG_REQ with the same index. Otherwise go FAULT.
  - A cmd_done outside CFG_WAIT is ignored.
- LOCKWAIT: timer counts while lock_in=1 and clears when lock_in=0. On reaching T_UNMUTE, go RUN, nmute<=1.
- RUN: lock_in=0 → nmute<=0 on the next edge, go LOCKWAIT (no reconfig, nenable stays 0).
- FAULT: nenable=1, nmute=0, seq_fault<=1. Exit only to OFF when ena=0 or seq_go=0; seq_fault is cleared on re-entry to PWRUP.
- Shutdown: ena=0 or seq_go=0 in any state except OFF/FAULT:
  - nmute<=0 at once, go MUTEDN.
  - MUTEDN counts T_MUTE cycles, then nenable<=1 and go OFF.
- Shutdown during CFG_REQ/CFG_WAIT: an outstanding cmd_valid is kept until accepted. MUTEDN still waits T_MUTE; late cmd_done is ignored.
- Shutdown has priority over lock loss and cmd_done in the same cycle.
- Timer: saturating CNT_W-bit up-counter, cleared on every state change. Terminal compare is count==T-1, i.e. exactly T cycles spent.
- The amplifier is never unmuted while nenable=1.

Optional Feature:
AMP_SEQ_RETRY_EN
- Defined: NACK retry up to MAX_RETRY as above.
- Undefined: the retry counter is not built and the first NACK goes directly to FAULT; MAX_RETRY is ignored.

Test Plan:
- Overrides for all tests: T_PWRUP=10, T_UNMUTE=5, T_MUTE=3, NUM_CFG=2.
- Nominal: reset, ena=seq_go=1, lock_in=1, cmd_ready=1, ACK.
  - nenable falls 1 cycle after go.
  - First cmd_valid 10 cycles later with cmd_reg=tbl_reg[0].
  - Two writes, then nmute rises 5 cycles after LOCKWAIT entry; seq_state=5.
- Backpressure: cmd_ready=0 for 7 cycles → cmd_valid and cmd_reg/cmd_data held stable, exactly one command accepted.
- NACK: idx 1 NACKed 3 times then ACK → 4 requests at idx 1, reaches RUN.
  - With 4 NACKs: seq_state=7, seq_fault=1, nenable=1.
  - With the macro undefined: FAULT after the first NACK.
- Lock loss: in RUN drop lock_in 1 cycle → nmute=0 next cycle, nenable stays 0, no new cmd_valid.
  - Restore lock → nmute=1 after 5 locked cycles.
  - A lock glitch at 3 cycles restarts the count.
- Shutdown: ena=0 in RUN → nmute=0 next cycle, nenable=1 after 3 more cycles, seq_state=0.
  - Repeat with ena=0 in CFG_WAIT: late cmd_done ignored, same timing.
- Reset mid-CFG_WAIT: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/amp_seq_ctrl.sv
// Power-up / register-config / mute sequencer for the external I2S amplifier.
// Optional feature macro: AMP_SEQ_RETRY_EN (NACK retry up to MAX_RETRY; undefined = first NACK faults).
module amp_seq_ctrl #(
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned T_PWRUP   = 480000,
  parameter int unsigned T_UNMUTE  = 48000,
  parameter int unsigned T_MUTE    = 4800,
  parameter int unsigned NUM_CFG   = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [6:0]  AMP_ADDR  = 7'h2C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       seq_go,
  input  logic       lock_in,
  output logic [3:0] tbl_idx,
  input  logic [7:0] tbl_reg,
  input  logic [7:0] tbl_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [6:0] cmd_addr,
  output logic [7:0] cmd_reg,
  output logic [7:0] cmd_data,
  input  logic       cmd_done,
  input  logic       cmd_nack,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic [2:0] seq_state,
  output logic       seq_fault
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWRUP    = 3'd1,
    S_CFG_REQ  = 3'd2,
    S_CFG_WAIT = 3'd3,
    S_LOCKWAIT = 3'd4,
    S_RUN      = 3'd5,
    S_MUTEDN   = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] UNMUTE_LAST = CNT_W'(T_UNMUTE - 1);
  localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(T_MUTE - 1);
  localparam logic [3:0]       IDX_LAST    = 4'(NUM_CFG - 1);

  // Elaboration-time guard on the table depth and retry range
  if (NUM_CFG < 1 || NUM_CFG > 16 || MAX_RETRY > 255) begin : g_param_chk
    $error("amp_seq_ctrl: NUM_CFG must be 1..16 and MAX_RETRY at most 255");
  end

`ifdef AMP_SEQ_RETRY_EN
  localparam int unsigned      RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry;
`endif

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             stop_req;
  logic             active;

  assign stop_req  = !ena || !seq_go;
  assign active    = (state != S_OFF) && (state != S_FAULT) && (state != S_MUTEDN);
  assign cmd_addr  = AMP_ADDR;
  assign seq_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_OFF;
      timer       <= '0;
      tbl_idx     <= '0;
      cmd_valid   <= 1'b0;
      cmd_reg     <= '0;
      cmd_data    <= '0;
      amp_nenable <= 1'b1;
      amp_nmute   <= 1'b0;
      seq_fault   <= 1'b0;
`ifdef AMP_SEQ_RETRY_EN
      retry       <= '0;
`endif
    end else begin
      if (timer != '1) timer <= timer + CNT_W'(1);
      // A request already presented is held until the master takes it, whatever the state
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;

      if (stop_req && active) begin
        amp_nmute <= 1'b0;
        state     <= S_MUTEDN;
        timer     <= '0;
      end else begin
        case (state)
          S_OFF: begin
            if (ena && seq_go && !cmd_valid) begin
              state       <= S_PWRUP;
              amp_nenable <= 1'b0;
              seq_fault   <= 1'b0;
              tbl_idx     <= '0;
              timer       <= '0;
            end
          end
          // tbl_idx is already 0 here, so the first request is presented on entry to CFG_REQ
          S_PWRUP: begin
            if (timer == PWRUP_LAST) begin
              state     <= S_CFG_REQ;
              tbl_idx   <= '0;
              cmd_reg   <= tbl_reg;
              cmd_data  <= tbl_data;
              cmd_valid <= 1'b1;
              timer     <= '0;
`ifdef AMP_SEQ_RETRY_EN
              retry     <= '0;
`endif
            end
          end
          S_CFG_REQ: begin
            if (!cmd_valid) begin
              cmd_reg   <= tbl_reg;
              cmd_data  <= tbl_data;
              cmd_valid <= 1'b1;
            end else if (cmd_ready) begin
              state <= S_CFG_WAIT;
              timer <= '0;
            end
          end
          S_CFG_WAIT: begin
            if (cmd_done) begin
              timer <= '0;
              if (!cmd_nack) begin
`ifdef AMP_SEQ_RETRY_EN
                retry <= '0;
`endif
                if (tbl_idx == IDX_LAST) begin
                  state   <= S_LOCKWAIT;
                  tbl_idx <= '0;
                end else begin
                  state   <= S_CFG_REQ;
                  tbl_idx <= tbl_idx + 4'd1;
                end
`ifdef AMP_SEQ_RETRY_EN
              end else if (retry < RETRY_MAX) begin
                retry <= retry + RETRY_W'(1);
                state <= S_CFG_REQ;
`endif
              end else begin
                state       <= S_FAULT;
                amp_nenable <= 1'b1;
                amp_nmute   <= 1'b0;
                seq_fault   <= 1'b1;
              end
            end
          end
          S_LOCKWAIT: begin
            if (!lock_in) begin
              timer <= '0;
            end else if (timer == UNMUTE_LAST) begin
              state     <= S_RUN;
              amp_nmute <= 1'b1;
              timer     <= '0;
            end
          end
          S_RUN: begin
            if (!lock_in) begin
              state     <= S_LOCKWAIT;
              amp_nmute <= 1'b0;
              timer     <= '0;
            end
          end
          S_MUTEDN: begin
            if (timer == MUTE_LAST) begin
              state       <= S_OFF;
              amp_nenable <= 1'b1;
              timer       <= '0;
            end
          end
          S_FAULT: begin
            amp_nenable <= 1'b1;
            amp_nmute   <= 1'b0;
            if (stop_req) begin
              state <= S_OFF;
              timer <= '0;
            end
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amp_seq_ctrl.sv
// Self-checking bench for amp_seq_ctrl: NACK vector table, scoreboard of I2C writes,
// and hand sequences for timing, backpressure, lock loss, shutdown and reset.
module tb_amp_seq_ctrl;

  localparam int unsigned T_PWRUP   = 10;
  localparam int unsigned T_UNMUTE  = 5;
  localparam int unsigned T_MUTE    = 3;
  localparam int unsigned NUM_CFG   = 2;
  localparam int unsigned MAX_RETRY = 3;
`ifdef AMP_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] d;
  } cmd_t;

  typedef struct {
    int         nacks;
    logic [2:0] exp_state;
    logic       exp_fault;
    logic       exp_nenable;
    logic       exp_nmute;
    int         exp_idx1;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena, seq_go, lock_in, cmd_ready, cmd_done, cmd_nack;
  logic [3:0] tbl_idx;
  logic [7:0] tbl_reg, tbl_data, cmd_reg, cmd_data;
  logic       cmd_valid, amp_nenable, amp_nmute, seq_fault;
  logic [6:0] cmd_addr;
  logic [2:0] seq_state;

  int   checks = 0;
  int   failures = 0;
  cmd_t exp_q[$];
  cmd_t mon_e;
  bit   acc_seen, acc_idx1, nack_next;
  int   acc_count, idx1_count, done_cnt, nack_left;
  vec_t vecs[4];

  always #5 clk = ~clk;

  function automatic logic [7:0] f_reg(input logic [3:0] i);
    return 8'h20 + 8'(i) * 8'd3;
  endfunction

  function automatic logic [7:0] f_data(input logic [3:0] i);
    return 8'h5A ^ {i, i};
  endfunction

  assign tbl_reg  = f_reg(tbl_idx);
  assign tbl_data = f_data(tbl_idx);

  amp_seq_ctrl #(
    .CNT_W(20), .T_PWRUP(T_PWRUP), .T_UNMUTE(T_UNMUTE), .T_MUTE(T_MUTE),
    .NUM_CFG(NUM_CFG), .MAX_RETRY(MAX_RETRY), .AMP_ADDR(7'h2C)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .seq_go(seq_go), .lock_in(lock_in),
    .tbl_idx(tbl_idx), .tbl_reg(tbl_reg), .tbl_data(tbl_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .cmd_done(cmd_done), .cmd_nack(cmd_nack),
    .amp_nenable(amp_nenable), .amp_nmute(amp_nmute),
    .seq_state(seq_state), .seq_fault(seq_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] i);
    cmd_t e;
    e.r = f_reg(i);
    e.d = f_data(i);
    exp_q.push_back(e);
  endtask

  // Scoreboard side: every accepted write is popped and compared
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      acc_seen = 1'b1;
      acc_count++;
      acc_idx1 = (cmd_reg == f_reg(4'd1));
      if (acc_idx1) idx1_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_cmd actual reg=%0h data=%0h required=no write", cmd_reg, cmd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_cmd", {16'h0, cmd_reg, cmd_data}, {16'h0, mon_e});
        chk("cmd_addr", {25'h0, cmd_addr}, 32'h2C);
      end
    end
  end

  // One clock; then the I2C master model answers each accepted write two cycles later
  task automatic step();
    @(posedge clk);
    #1;
    cmd_done = 1'b0;
    cmd_nack = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        cmd_done = 1'b1;
        cmd_nack = nack_next;
      end
    end
    if (acc_seen) begin
      acc_seen  = 1'b0;
      done_cnt  = 2;
      nack_next = 1'b0;
      if (acc_idx1 && nack_left > 0) begin
        nack_next = 1'b1;
        nack_left--;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ena = 1'b0; seq_go = 1'b0; lock_in = 1'b0;
    cmd_ready = 1'b0; cmd_done = 1'b0; cmd_nack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    acc_seen = 1'b0; acc_idx1 = 1'b0; nack_next = 1'b0;
    done_cnt = 0; nack_left = 0; acc_count = 0; idx1_count = 0;
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc);
    int n;
    n = 0;
    while (seq_state !== s && n < maxc) begin
      step();
      n++;
    end
    chk("wait_state", {29'h0, seq_state}, {29'h0, s});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_nenable"}, {31'h0, amp_nenable}, 32'd1);
    chk({tag, "_nmute"},   {31'h0, amp_nmute},   32'd0);
    chk({tag, "_valid"},   {31'h0, cmd_valid},   32'd0);
    chk({tag, "_idx"},     {28'h0, tbl_idx},     32'd0);
    chk({tag, "_regdata"}, {16'h0, cmd_reg, cmd_data}, 32'd0);
    chk({tag, "_state"},   {29'h0, seq_state},   32'd0);
    chk({tag, "_fault"},   {31'h0, seq_fault},   32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    bit saw_valid;

    // NACK table: expectations depend on whether the retry feature is built
    vecs[0] = '{0, 3'd5, 1'b0, 1'b0, 1'b1, 1};
    if (RETRY) begin
      vecs[1] = '{1, 3'd5, 1'b0, 1'b0, 1'b1, 2};
      vecs[2] = '{3, 3'd5, 1'b0, 1'b0, 1'b1, 4};
      vecs[3] = '{4, 3'd7, 1'b1, 1'b1, 1'b0, 4};
    end else begin
      vecs[1] = '{1, 3'd7, 1'b1, 1'b1, 1'b0, 1};
      vecs[2] = '{3, 3'd7, 1'b1, 1'b1, 1'b0, 1};
      vecs[3] = '{4, 3'd7, 1'b1, 1'b1, 1'b0, 1};
    end

    do_reset();
    chk_reset_vals("rst");

    // Nominal bring-up with timing checks
    push_exp(4'd0);
    push_exp(4'd1);
    lock_in = 1'b1; cmd_ready = 1'b1; ena = 1'b1; seq_go = 1'b1;
    step();
    chk("nen_fall", {31'h0, amp_nenable}, 32'd0);
    chk("pwrup_state", {29'h0, seq_state}, 32'd1);
    n = 0;
    while (!cmd_valid && n < 50) begin step(); n++; end
    chk("valid_latency", n, T_PWRUP);
    chk("first_reg", {24'h0, cmd_reg}, {24'h0, f_reg(4'd0)});
    chk("first_data", {24'h0, cmd_data}, {24'h0, f_data(4'd0)});
    wait_state(3'd4, 60);
    n = 0;
    while (!amp_nmute && n < 50) begin step(); n++; end
    chk("unmute_latency", n, T_UNMUTE);
    chk("run_state", {29'h0, seq_state}, 32'd5);
    chk("run_nenable", {31'h0, amp_nenable}, 32'd0);
    chk("nominal_drain", exp_q.size(), 0);

    // Lock loss for one cycle, then relock
    acc0 = acc_count;
    saw_valid = 1'b0;
    lock_in = 1'b0;
    step();
    lock_in = 1'b1;
    chk("lockloss_nmute", {31'h0, amp_nmute}, 32'd0);
    chk("lockloss_nenable", {31'h0, amp_nenable}, 32'd0);
    chk("lockloss_state", {29'h0, seq_state}, 32'd4);
    n = 0;
    while (!amp_nmute && n < 50) begin step(); n++; saw_valid |= cmd_valid; end
    chk("relock_latency", n, T_UNMUTE);

    // Lock glitch after 3 locked cycles restarts the count
    lock_in = 1'b0;
    step();
    lock_in = 1'b1;
    repeat (3) begin step(); saw_valid |= cmd_valid; end
    lock_in = 1'b0;
    step();
    lock_in = 1'b1;
    chk("glitch_nmute", {31'h0, amp_nmute}, 32'd0);
    n = 0;
    while (!amp_nmute && n < 50) begin step(); n++; saw_valid |= cmd_valid; end
    chk("glitch_relock_latency", n, T_UNMUTE);
    chk("lock_no_recfg_valid", {31'h0, saw_valid}, 32'd0);
    chk("lock_no_recfg_count", acc_count, acc0);

    // Shutdown from RUN
    ena = 1'b0;
    step();
    chk("sd_run_nmute", {31'h0, amp_nmute}, 32'd0);
    chk("sd_run_state", {29'h0, seq_state}, 32'd6);
    chk("sd_run_nenable_held", {31'h0, amp_nenable}, 32'd0);
    n = 0;
    while (!amp_nenable && n < 20) begin step(); n++; end
    chk("sd_run_mute_time", n, T_MUTE);
    chk("sd_run_off", {29'h0, seq_state}, 32'd0);

    // Backpressure: ready held low for 7 cycles once the request appears
    do_reset();
    push_exp(4'd0);
    push_exp(4'd1);
    lock_in = 1'b1; cmd_ready = 1'b0; ena = 1'b1; seq_go = 1'b1;
    n = 0;
    while (!cmd_valid && n < 50) begin step(); n++; end
    for (int i = 0; i < 7; i++) begin
      step();
      chk("bp_valid", {31'h0, cmd_valid}, 32'd1);
      chk("bp_stable", {16'h0, cmd_reg, cmd_data}, {16'h0, f_reg(4'd0), f_data(4'd0)});
    end
    chk("bp_none_accepted", acc_count, 0);
    cmd_ready = 1'b1;
    step();
    chk("bp_valid_drop", {31'h0, cmd_valid}, 32'd0);
    chk("bp_one_accepted", acc_count, 1);
    chk("bp_wait_state", {29'h0, seq_state}, 32'd3);
    wait_state(3'd5, 80);
    chk("bp_drain", exp_q.size(), 0);

    // NACK vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      nack_left = vecs[v].nacks;
      push_exp(4'd0);
      for (int k = 0; k < vecs[v].exp_idx1; k++) push_exp(4'd1);
      lock_in = 1'b1; cmd_ready = 1'b1; ena = 1'b1; seq_go = 1'b1;
      n = 0;
      while (seq_state != 3'd5 && seq_state != 3'd7 && n < 300) begin step(); n++; end
      chk("nack_state", {29'h0, seq_state}, {29'h0, vecs[v].exp_state});
      chk("nack_fault", {31'h0, seq_fault}, {31'h0, vecs[v].exp_fault});
      chk("nack_nenable", {31'h0, amp_nenable}, {31'h0, vecs[v].exp_nenable});
      chk("nack_nmute", {31'h0, amp_nmute}, {31'h0, vecs[v].exp_nmute});
      chk("nack_idx1_reqs", idx1_count, vecs[v].exp_idx1);
      chk("nack_drain", exp_q.size(), 0);
    end

    // Leave FAULT via seq_go=0; the fault flag clears on the next power-up
    seq_go = 1'b0;
    step();
    chk("fault_exit_state", {29'h0, seq_state}, 32'd0);
    chk("fault_sticky", {31'h0, seq_fault}, 32'd1);
    seq_go = 1'b1;
    step();
    chk("fault_restart_state", {29'h0, seq_state}, 32'd1);
    chk("fault_cleared", {31'h0, seq_fault}, 32'd0);

    // Shutdown while waiting on cmd_done; the late done must be ignored
    do_reset();
    push_exp(4'd0);
    lock_in = 1'b1; cmd_ready = 1'b1; ena = 1'b1; seq_go = 1'b1;
    wait_state(3'd3, 60);
    acc0 = acc_count;
    ena = 1'b0;
    step();
    chk("sd_wait_state", {29'h0, seq_state}, 32'd6);
    chk("sd_wait_nmute", {31'h0, amp_nmute}, 32'd0);
    n = 0;
    while (!amp_nenable && n < 20) begin step(); n++; end
    chk("sd_wait_mute_time", n, T_MUTE);
    chk("sd_wait_off", {29'h0, seq_state}, 32'd0);
    chk("sd_wait_idx", {28'h0, tbl_idx}, 32'd0);
    chk("sd_wait_no_cmd", acc_count, acc0);

    // Asynchronous reset in the middle of CFG_WAIT
    do_reset();
    push_exp(4'd0);
    lock_in = 1'b1; cmd_ready = 1'b1; ena = 1'b1; seq_go = 1'b1;
    wait_state(3'd3, 60);
    done_cnt = 0;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
